// File: rtl/ethernet_frame_buffer_if.sv
// ethernet_frame_buffer_if: byte-wide AXI-Stream style bundle used for the
// ingress and egress ports of ethernet_frame_buffer.
//   tdata  [7:0] payload byte
//   tvalid       byte is presented by the master
//   tready       slave accepts the byte
//   tlast        last byte of a frame
//   tuser        on the tlast beat: frame is bad
interface ethernet_frame_buffer_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;
   logic       tlast;
   logic       tuser;

   modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
   modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/ethernet_frame_buffer.sv
// ethernet_frame_buffer: byte FIFO between an ingress and egress frame stream.
// Default build is cut-through (every accepted byte becomes readable at once,
// tuser forwarded on the tlast beat). Defining
// ETHERNET_FRAME_BUFFER_STORE_AND_FORWARD_EN selects store-and-forward: bytes
// become readable only when a good frame completes; bad frames and frames
// larger than the buffer are dropped and counted.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   s_axis (slave)       ingress byte stream
//   m_axis (master)      egress byte stream
//   fifo_is_almost_full  occupancy >= ALMOST_FULL_THRESHOLD (registered)
//   occupancy            bytes written and not yet read
//   drop_count           frames discarded, saturating
module ethernet_frame_buffer #(
   parameter int unsigned DEPTH                 = 256,
   parameter int unsigned ALMOST_FULL_THRESHOLD = 224
) (
   input  logic                    clk,
   input  logic                    rstn,
   ethernet_frame_buffer_if.slave  s_axis,
   ethernet_frame_buffer_if.master m_axis,
   output logic                    fifo_is_almost_full,
   output logic [$clog2(DEPTH):0]  occupancy,
   output logic [15:0]             drop_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned MW = 10;

   typedef enum logic [1:0] {IDLE, FRAME, DISCARD} state_t;

   logic [MW-1:0] mem [DEPTH];

   state_t        state_q, state_nxt;
   logic [PW-1:0] wr_ptr, wr_ptr_nxt;
   logic [PW-1:0] commit_ptr, commit_nxt;
   logic [PW-1:0] rd_ptr, rd_ptr_nxt;
   logic [PW-1:0] fetch_ptr;
   logic [PW-1:0] occ_nxt;
   logic [15:0]   drop_nxt;
   logic          s_ready_q;
   logic          mem_we;
   logic          wr_hs;
   logic [MW-1:0] wdata;

   // egress pipeline: RAM read register feeding a 2-entry output queue
   logic          ram_vld;
   logic [MW-1:0] ram_q;
   logic          ob0_vld, ob1_vld;
   logic [MW-1:0] ob0, ob1;
   logic          pop;
   logic [1:0]    fill_after;
   logic          fetch_en;

   assign wr_hs = s_axis.tvalid & s_ready_q;
   assign pop   = ob0_vld & m_axis.tready;

`ifdef ETHERNET_FRAME_BUFFER_STORE_AND_FORWARD_EN
   assign wdata = {1'b0, s_axis.tlast, s_axis.tdata};
`else
   assign wdata = {s_axis.tuser & s_axis.tlast, s_axis.tlast, s_axis.tdata};
`endif

   // ingress FSM: next state, pointer and drop bookkeeping
   always_comb begin
      state_nxt  = state_q;
      wr_ptr_nxt = wr_ptr;
      commit_nxt = commit_ptr;
      drop_nxt   = drop_count;
      mem_we     = 1'b0;
      rd_ptr_nxt = rd_ptr + PW'(pop);
      unique case (state_q)
         IDLE, FRAME: begin
            if (wr_hs) begin
               mem_we     = 1'b1;
               wr_ptr_nxt = wr_ptr + PW'(1);
               state_nxt  = s_axis.tlast ? IDLE : FRAME;
            end
         end
         DISCARD: begin
            if (wr_hs && s_axis.tlast) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
`ifdef ETHERNET_FRAME_BUFFER_STORE_AND_FORWARD_EN
      if (mem_we && s_axis.tlast) begin
         if (s_axis.tuser) begin
            wr_ptr_nxt = commit_ptr;
            drop_nxt   = (drop_count == 16'hFFFF) ? drop_count : drop_count + 16'd1;
         end else begin
            commit_nxt = wr_ptr_nxt;
         end
      end else if ((state_q == FRAME) && mem_we &&
                   ((wr_ptr_nxt - rd_ptr_nxt) == PW'(DEPTH)) &&
                   (commit_ptr == rd_ptr_nxt)) begin
         // frame filled the whole buffer with nothing else queued: it can never fit
         wr_ptr_nxt = commit_ptr;
         state_nxt  = DISCARD;
         drop_nxt   = (drop_count == 16'hFFFF) ? drop_count : drop_count + 16'd1;
      end
`else
      commit_nxt = wr_ptr_nxt;
`endif
      occ_nxt = wr_ptr_nxt - rd_ptr_nxt;
   end

   // fetch only if the fetched byte will have a slot when it arrives next cycle
   always_comb begin
      fill_after = 2'(ob0_vld) + 2'(ob1_vld) + 2'(ram_vld) - 2'(pop);
      fetch_en   = (commit_ptr != fetch_ptr) && (fill_after <= 2'd1);
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q             <= IDLE;
         wr_ptr              <= '0;
         commit_ptr          <= '0;
         rd_ptr              <= '0;
         fetch_ptr           <= '0;
         drop_count          <= '0;
         occupancy           <= '0;
         fifo_is_almost_full <= 1'b0;
         s_ready_q           <= 1'b0;
         ram_vld             <= 1'b0;
         ram_q               <= '0;
         ob0_vld             <= 1'b0;
         ob0                 <= '0;
         ob1_vld             <= 1'b0;
         ob1                 <= '0;
      end else begin
         state_q             <= state_nxt;
         wr_ptr              <= wr_ptr_nxt;
         commit_ptr          <= commit_nxt;
         rd_ptr              <= rd_ptr_nxt;
         drop_count          <= drop_nxt;
         occupancy           <= occ_nxt;
         fifo_is_almost_full <= (occupancy >= PW'(ALMOST_FULL_THRESHOLD));
         s_ready_q           <= (occ_nxt < PW'(DEPTH)) || (state_nxt == DISCARD);
         ram_vld             <= fetch_en;
         if (fetch_en) begin
            ram_q     <= mem[fetch_ptr[AW-1:0]];
            fetch_ptr <= fetch_ptr + PW'(1);
         end
         // output queue: head only changes when consumed or empty
         if (pop) begin
            if (ob1_vld) begin
               ob0     <= ob1;
               ob0_vld <= 1'b1;
               ob1     <= ram_q;
               ob1_vld <= ram_vld;
            end else begin
               ob0     <= ram_q;
               ob0_vld <= ram_vld;
            end
         end else if (ram_vld) begin
            if (!ob0_vld) begin
               ob0     <= ram_q;
               ob0_vld <= 1'b1;
            end else begin
               ob1     <= ram_q;
               ob1_vld <= 1'b1;
            end
         end
      end
   end

   assign s_axis.tready = s_ready_q;
   assign m_axis.tvalid = ob0_vld;
   assign m_axis.tdata  = ob0[7:0];
   assign m_axis.tlast  = ob0[8];
   assign m_axis.tuser  = ob0[9];

endmodule

// File: doc/ethernet_frame_buffer.md
ETHERNET_FRAME_BUFFER -- requirements
Module: ethernet_frame_buffer

Interface
REQ-001 Parameter DEPTH, default 256, byte entries; power of two, 16..4096.
REQ-002 Parameter ALMOST_FULL_THRESHOLD, default 224, occupancy at which fifo_is_almost_full asserts; 1..DEPTH.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 s_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  8/1/1/1/1  ingress byte stream; tuser=1 on the tlast beat marks a bad frame.
REQ-006 m_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  8/1/1/1/1  egress byte stream.
REQ-007 fifo_is_almost_full  output  1  registered occupancy >= ALMOST_FULL_THRESHOLD; drives the upstream ethernet_frame_dropper.
REQ-008 occupancy  output  clog2(DEPTH)+1  bytes written (committed or not) and not yet read.
REQ-009 drop_count  output  16  frames discarded; saturates at 0xFFFF.

Function
REQ-010 Storage SHALL be a DEPTH x 10-bit RAM (data, tlast, tuser) with wr_ptr, commit_ptr, rd_ptr, each clog2(DEPTH)+1 bits, wrapping modulo 2*DEPTH.
REQ-011 Write handshake = s_axis_tvalid & s_axis_tready; read handshake = m_axis_tvalid & m_axis_tready.
REQ-012 s_axis_tready SHALL be high when occupancy < DEPTH, or while in DISCARD state.
REQ-013 occupancy SHALL equal wr_ptr - rd_ptr, updated the cycle after each handshake; simultaneous write and read leave it unchanged.
REQ-014 fifo_is_almost_full SHALL update one cycle after occupancy crosses ALMOST_FULL_THRESHOLD in either direction.
REQ-015 m_axis SHALL sustain one byte per cycle with continuous m_axis_tready; m_axis_tdata/tlast/tuser SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-016 Readable data SHALL be bytes up to commit_ptr; an empty FIFO receiving a readable byte SHALL raise m_axis_tvalid exactly 2 cycles after that byte becomes readable.
REQ-017 Ingress write FSM states: IDLE (between frames), FRAME (frame in progress), DISCARD (accept and drop bytes until tlast).
REQ-018 IDLE->FRAME on write handshake with tlast=0; FRAME->IDLE on write handshake with tlast=1; single-byte frames stay in IDLE.
REQ-019 FRAME->DISCARD when occupancy==DEPTH and commit_ptr==rd_ptr (frame larger than the buffer); wr_ptr SHALL rewind to commit_ptr, drop_count SHALL increment once; DISCARD->IDLE on tlast handshake.
REQ-020 A tlast handshake arriving in the same cycle as the read that empties the FIFO SHALL be committed with no byte loss.

Reset
REQ-021 On rstn=0, asynchronously: all pointers 0, FSM IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, fifo_is_almost_full=0, occupancy=0, drop_count=0, s_axis_tready=0.
REQ-022 s_axis_tready SHALL rise the first cycle after rstn deasserts; a frame interrupted by reset is lost entirely, with no partial frame emitted afterwards.

Configuration
REQ-023 Macro ETHERNET_FRAME_BUFFER_STORE_AND_FORWARD_EN defined: commit_ptr advances only on the tlast handshake of a good frame; a tlast beat with tuser=1 rewinds wr_ptr to commit_ptr and increments drop_count; m_axis_tuser is always 0; REQ-019 is active.
REQ-024 Macro undefined: commit_ptr tracks wr_ptr every cycle (cut-through); tuser is passed through on the tlast beat; no rewinds; FSM DISCARD unreachable; drop_count stays 0.

Verification
REQ-025 64-byte frame, m_axis_tready=1, macro on -> first m_axis byte 2 cycles after the tlast handshake, 64 bytes identical, tlast on byte 64.
REQ-026 Same frame, macro off -> first m_axis byte 2 cycles after the first write handshake.
REQ-027 m_axis_tready=0, write 224 bytes -> fifo_is_almost_full=1 one cycle after byte 224 is accepted; read one byte -> deasserts one cycle after occupancy=223.
REQ-028 Macro on, 100-byte frame with tuser=1 on tlast, then a 60-byte good frame -> only the 60-byte frame is output; drop_count=1.
REQ-029 Macro on, DEPTH=256, m_axis_tready=0, 300-byte frame -> s_axis_tready stays 1, frame discarded, drop_count=1, occupancy=0; a following 40-byte frame is output intact.
REQ-030 Assert rstn=0 mid-frame at byte 30, release, send a 64-byte frame -> only the 64-byte frame appears; outputs match REQ-021 during reset.
